// File: rtl/game_pkg.sv
// Shared encodings for the PS/2 movement front end: directions, scan codes and repeat FSM states.
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Bit 8 marks the E0 extended prefix.
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_W     = 9'h01D;
    localparam logic [8:0] KEY_S     = 9'h01B;
    localparam logic [8:0] KEY_A     = 9'h01C;
    localparam logic [8:0] KEY_D     = 9'h023;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Highest-priority set bit of a {right, left, down, up} vector: up > down > left > right.
    function automatic logic [1:0] prio_dir(input logic [3:0] h);
        logic [1:0] d;
        d = DIR_RIGHT;
        if (h[0])      d = DIR_UP;
        else if (h[1]) d = DIR_DOWN;
        else if (h[2]) d = DIR_LEFT;
        return d;
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// Loadable down-counter; expire pulses for one cycle when an armed count reaches zero.
module repeat_timer #(
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= load_val;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            // Disarm at zero so an un-reloaded expiry does not repeat every cycle.
            if (cnt_q == '0) armed_q <= 1'b0;
            else             cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign expire = armed_q && (cnt_q == '0);

endmodule

// File: rtl/ps2_move_cmd.sv
// PS/2 key events to movement/action commands with held-key auto-repeat.
// Optional build macro PS2_MOVE_WASD_EN adds W/A/S/D as aliases of the arrow keys.
module ps2_move_cmd
    import game_pkg::*;
#(
    parameter int REPEAT_DELAY  = 5_000_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int CNT_W         = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play_en,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_break,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] held,
    output logic       fire,
    output logic       pause_tgl,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

    logic       ev_make, ev_break;
    logic [3:0] arrow_hit, arrow_q, arrow_d, arrow_new;
    logic [3:0] wasd_d, wasd_new;
    logic [3:0] held_q, held_d, press_new;
    logic       any_new, cur_lost;
    logic [1:0] cur_q, cur_d;
    logic       space_hit, space_q, space_d, fire_d;
    logic       enter_hit, enter_q, enter_d, pause_d;
    rpt_state_e state_q, state_d;
    logic       pulse, t_clear, t_load, t_expire;
    logic [CNT_W-1:0] t_load_val;

    assign ev_make  = key_valid & ~key_break;
    assign ev_break = key_valid &  key_break;

    assign arrow_hit = {key_code == KEY_RIGHT, key_code == KEY_LEFT,
                        key_code == KEY_DOWN,  key_code == KEY_UP};
    assign arrow_d   = ev_make  ? (arrow_q | arrow_hit) :
                       ev_break ? (arrow_q & ~arrow_hit) : arrow_q;
    // Only a 0->1 of a pressed bit counts; keyboard typematic makes fall out here.
    assign arrow_new = {4{ev_make}} & arrow_hit & ~arrow_q;

`ifdef PS2_MOVE_WASD_EN
    logic [3:0] wasd_hit, wasd_q;
    assign wasd_hit = {key_code == KEY_D, key_code == KEY_A,
                       key_code == KEY_S, key_code == KEY_W};
    assign wasd_d   = ev_make  ? (wasd_q | wasd_hit) :
                      ev_break ? (wasd_q & ~wasd_hit) : wasd_q;
    assign wasd_new = {4{ev_make}} & wasd_hit & ~wasd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wasd_q <= '0;
        else        wasd_q <= wasd_d;
    end
`else
    assign wasd_d   = '0;
    assign wasd_new = '0;
`endif

    assign held_d    = arrow_d | wasd_d;
    assign press_new = arrow_new | wasd_new;
    assign any_new   = |press_new;

    assign space_hit = (key_code == KEY_SPACE);
    assign enter_hit = (key_code == KEY_ENTER);
    assign space_d   = (ev_make & space_hit) | (space_q & ~(ev_break & space_hit));
    assign enter_d   = (ev_make & enter_hit) | (enter_q & ~(ev_break & enter_hit));
    assign fire_d    = play_en & ev_make & space_hit & ~space_q;
    assign pause_d   = play_en & ev_make & enter_hit & ~enter_q;

    // Newest press wins; losing cur to a release falls back to the priority order.
    always_comb begin
        cur_d    = cur_q;
        cur_lost = 1'b0;
        if (any_new) begin
            cur_d = prio_dir(press_new);
        end else if ((held_d != '0) && !held_d[cur_q]) begin
            cur_d    = prio_dir(held_d);
            cur_lost = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Key transitions are tested before expiry so a coincident expiry is dropped.
    always_comb begin
        state_d    = state_q;
        pulse      = 1'b0;
        t_clear    = 1'b0;
        t_load     = 1'b0;
        t_load_val = DELAY_LD;
        if (!play_en || (held_d == '0)) begin
            state_d = ST_IDLE;
            t_clear = 1'b1;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_DELAY;
            t_load  = 1'b1;
            pulse   = any_new;
        end else if (any_new) begin
            state_d = ST_DELAY;
            t_load  = 1'b1;
            pulse   = 1'b1;
        end else if (cur_lost) begin
            state_d = ST_DELAY;
            t_load  = 1'b1;
        end else if (t_expire) begin
            state_d    = ST_REPEAT;
            t_load     = 1'b1;
            t_load_val = PERIOD_LD;
            pulse      = 1'b1;
        end
    end

    repeat_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (t_clear),
        .load     (t_load),
        .load_val (t_load_val),
        .expire   (t_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrow_q    <= '0;
            held_q     <= '0;
            cur_q      <= DIR_UP;
            space_q    <= 1'b0;
            enter_q    <= 1'b0;
            move_valid <= 1'b0;
            move_dir   <= DIR_UP;
            fire       <= 1'b0;
            pause_tgl  <= 1'b0;
        end else begin
            arrow_q    <= arrow_d;
            held_q     <= held_d;
            cur_q      <= cur_d;
            space_q    <= space_d;
            enter_q    <= enter_d;
            move_valid <= pulse;
            if (pulse) move_dir <= cur_d;
            fire       <= fire_d;
            pause_tgl  <= pause_d;
        end
    end

    assign held      = held_q;
    assign dbg_state = state_q;

endmodule
